dmem_scan_checker: RTL
======================

// Module: dmem_scan_checker
//
// PURPOSE
//   Run-and-check sequencer that sits downstream of the single-cycle CPU's
//   data memory.
//   - Releases the CPU from reset and lets it run for a fixed number of cycles.
//   - Then holds the CPU in reset and walks the low NUM_WORDS words of dmem,
//     one word per cycle, through a scan read port.
//   - Compares each word against an expected-value ROM and reports pass/fail,
//     mismatch count and the first failing index.
//   - Synthesizable replacement for bench-side memory dumping; usable on FPGA.
//
// PARAMETERS
//   RUN_CYCLES  1000  clocks the CPU runs with cpu_reset low
//   NUM_WORDS   32    dmem words scanned and checked, starting at word 0
//   WORD_BYTES  4     byte stride between scanned words
//   IW          5     index width, $clog2(NUM_WORDS)
//   CW          6     fail counter width, $clog2(NUM_WORDS+1)
//
// PORTS
//   clk             in   1   system clock; all state updates on posedge
//   reset           in   1   asynchronous, active-high reset
//   cpu_reset       out  1   drives CPU reset; low only in RUN
//   scan_en         out  1   selects scan port onto dmem address; high only in SCAN
//   scan_daddr      out  32  dmem byte address = idx*WORD_BYTES
//   scan_drdata     in   32  dmem read data; combinational from scan_daddr
//   exp_idx         out  IW  expected-ROM index (= idx)
//   exp_data        in   32  expected word; combinational from exp_idx
//   mismatch_pulse  out  1   1-cycle registered pulse per mismatching word
//   fail_count      out  CW  number of mismatching words so far
//   first_fail_idx  out  IW  index of first mismatch; valid when fail_count != 0
//   done            out  1   scan complete; sticky until reset
//   pass            out  1   done && fail_count == 0; sticky until reset
//
// BEHAVIOUR
//   Reset (async, any state):
//   - Registered outputs and state clear immediately: state=IDLE, cnt=0,
//     idx=0, done=0, pass=0, fail_count=0, first_fail_idx=0, mismatch_pulse=0.
//   - Combinational outputs follow the IDLE state: cpu_reset=1, scan_en=0,
//     scan_daddr=0, exp_idx=0.
//   - Reset mid-RUN or mid-SCAN aborts; no partial result is retained.
//   FSM, all transitions on posedge:
//   - IDLE: always -> RUN next edge; cnt cleared to 0.
//   - RUN: cnt increments each edge. When cnt==RUN_CYCLES-1 -> SCAN with idx=0.
//     cpu_reset is low for exactly RUN_CYCLES clock periods.
//   - SCAN: compare scan_drdata vs exp_data in the same cycle.
//     On mismatch (any bit differs; any X/Z counts as mismatch in sim):
//       - fail_count increments at the next edge.
//       - mismatch_pulse=1 for the following cycle.
//       - first_fail_idx<=idx, but only if fail_count==0.
//     idx increments each edge. When idx==NUM_WORDS-1 -> DONE.
//   - DONE: terminal. done=1 and pass=(fail_count==0) are registered on the
//     SCAN->DONE edge, including the last word's result.
//   Decode and widths:
//   - cpu_reset = reset | (state!=RUN); scan_en = (state==SCAN).
//   - scan_daddr and exp_idx are decoded combinationally from idx; they are
//     0 outside SCAN.
//   - cnt is wide enough for RUN_CYCLES-1; it never wraps.
//   - fail_count cannot exceed NUM_WORDS; no saturation logic is required.
//   Latency:
//   - From the first posedge after reset deasserts, done rises after
//     1 + RUN_CYCLES + NUM_WORDS edges.
//   RUN_CYCLES==0 is illegal; enforced by an elaboration-time check.
//
// TESTING  (RUN_CYCLES=10, NUM_WORDS=32 unless noted)
//   1 All dmem words equal to ROM -> cpu_reset low exactly 10 cycles;
//     done=1 and pass=1 on edge 43; fail_count=0.
//   2 Words 5 and 17 corrupted -> fail_count=2, first_fail_idx=5, pass=0;
//     two 1-cycle mismatch_pulse.
//   3 Every word differs -> fail_count=32, first_fail_idx=0, pass=0,
//     mismatch_pulse high 32 consecutive cycles.
//   4 Reset asserted while idx=12 in SCAN -> outputs at reset values before
//     next edge; rerun from IDLE gives fresh result equal to case 1.
//   5 scan_drdata=X for word 3 only -> fail_count=1, first_fail_idx=3.
//   6 Address sweep -> scan_daddr 0,4,...,124 on successive cycles;
//     scan_en high exactly 32 cycles; CPU dwe never high while cpu_reset=1.

Source files
------------

// File: rtl/dmem_scan_checker_if.sv
// dmem_scan_checker_if
//   Groups the scan read port, the expected-ROM port, the CPU reset and the
//   result/status signals of dmem_scan_checker.
//   Handshake: none. scan_drdata and exp_data are combinational responses to
//   scan_daddr and exp_idx, and the checker samples them in the same cycle.
//   The master modport is the checker side. The slave modport is the
//   memory / ROM / observer side.
//   Signals:
//     cpu_reset       CPU reset; low only while the CPU is running
//     scan_en         scan port owns the dmem address
//     scan_daddr      dmem byte address of the word being scanned
//     scan_drdata     dmem read data
//     exp_idx         expected-ROM index
//     exp_data        expected word
//     mismatch_pulse  one-cycle pulse per mismatching word
//     fail_count      mismatching words so far
//     first_fail_idx  index of the first mismatch
//     done / pass     sticky scan-complete / scan-passed flags
//     dbg_state       FSM state, for observation only
interface dmem_scan_checker_if #(
  parameter int IW = 5,
  parameter int CW = 6
);
  logic          cpu_reset;
  logic          scan_en;
  logic [31:0]   scan_daddr;
  logic [31:0]   scan_drdata;
  logic [IW-1:0] exp_idx;
  logic [31:0]   exp_data;
  logic          mismatch_pulse;
  logic [CW-1:0] fail_count;
  logic [IW-1:0] first_fail_idx;
  logic          done;
  logic          pass;
  logic [1:0]    dbg_state;

  modport master (
    output cpu_reset, scan_en, scan_daddr, exp_idx,
    output mismatch_pulse, fail_count, first_fail_idx, done, pass, dbg_state,
    input  scan_drdata, exp_data
  );

  modport slave (
    input  cpu_reset, scan_en, scan_daddr, exp_idx,
    input  mismatch_pulse, fail_count, first_fail_idx, done, pass, dbg_state,
    output scan_drdata, exp_data
  );
endinterface

// File: rtl/dmem_scan_checker.sv
// dmem_scan_checker
//   Run-and-check sequencer for the single-cycle CPU. It first releases the
//   CPU from reset for RUN_CYCLES clocks. It then holds the CPU in reset and
//   walks dmem words 0..NUM_WORDS-1, one word per cycle. Each word is compared
//   against an expected-value ROM, and the block reports the mismatch count,
//   the first failing index and a sticky pass/done result.
//   Ports:
//     clk    system clock; all state changes on the rising edge
//     reset  asynchronous, active-high reset
//     bus    dmem_scan_checker_if.master (scan port, ROM port, results)
module dmem_scan_checker #(
  parameter int RUN_CYCLES = 1000,
  parameter int NUM_WORDS  = 32,
  parameter int WORD_BYTES = 4,
  parameter int IW         = 5,
  parameter int CW         = 6
) (
  input  logic                   clk,
  input  logic                   reset,
  dmem_scan_checker_if.master    bus
);

  // A run length of zero has no meaning.
  generate
    if (RUN_CYCLES == 0) begin : g_bad_run_cycles
      $error("dmem_scan_checker: RUN_CYCLES must be nonzero");
    end
  endgenerate

  // The counter only has to reach RUN_CYCLES-1.
  localparam int CNT_W = (RUN_CYCLES > 1) ? $clog2(RUN_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RUN_CYCLES - 1);
  localparam logic [IW-1:0]    IDX_LAST = IW'(NUM_WORDS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_SCAN = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           r_state, w_next_state;
  logic [CNT_W-1:0] r_cnt;
  logic [IW-1:0]    r_idx;
  logic             r_done;
  logic             r_pass;
  logic [CW-1:0]    r_fail_count;
  logic [IW-1:0]    r_first_fail_idx;
  logic             r_mismatch_pulse;
  logic             w_mismatch;

  // Case inequality is used so that an X or Z on either side counts as a
  // mismatch in simulation. Hardware reduces this to a plain compare.
  assign w_mismatch = (bus.scan_drdata !== bus.exp_data);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  w_next_state = S_RUN;
      S_RUN:   if (r_cnt == CNT_LAST) w_next_state = S_SCAN;
      S_SCAN:  if (r_idx == IDX_LAST) w_next_state = S_DONE;
      S_DONE:  w_next_state = S_DONE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Datapath: run counter, scan index and result registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt            <= '0;
      r_idx            <= '0;
      r_done           <= 1'b0;
      r_pass           <= 1'b0;
      r_fail_count     <= '0;
      r_first_fail_idx <= '0;
      r_mismatch_pulse <= 1'b0;
    end else begin
      r_mismatch_pulse <= 1'b0;
      case (r_state)
        S_IDLE: r_cnt <= '0;
        S_RUN: begin
          // Hold on the last count so the counter never wraps. The index
          // starts at word 0 when the scan begins.
          if (r_cnt == CNT_LAST) r_idx <= '0;
          else                   r_cnt <= r_cnt + 1'b1;
        end
        S_SCAN: begin
          if (w_mismatch) begin
            r_fail_count     <= r_fail_count + 1'b1;
            r_mismatch_pulse <= 1'b1;
            if (r_fail_count == '0) r_first_fail_idx <= r_idx;
          end
          if (r_idx == IDX_LAST) begin
            // The last word's compare result is folded into the pass flag.
            r_done <= 1'b1;
            r_pass <= (r_fail_count == '0) && !w_mismatch;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Output decode
  always_comb begin
    bus.cpu_reset  = reset | (r_state != S_RUN);
    bus.scan_en    = (r_state == S_SCAN);
    bus.scan_daddr = '0;
    bus.exp_idx    = '0;
    if (r_state == S_SCAN) begin
      bus.scan_daddr = 32'(r_idx) * 32'(WORD_BYTES);
      bus.exp_idx    = r_idx;
    end
  end

  assign bus.mismatch_pulse = r_mismatch_pulse;
  assign bus.fail_count     = r_fail_count;
  assign bus.first_fail_idx = r_first_fail_idx;
  assign bus.done           = r_done;
  assign bus.pass           = r_pass;
  assign bus.dbg_state      = r_state;

endmodule
